pipeline_fetch: RTL and testbench

- Instruction-fetch stage directly downstream of the pipelined core's PC register.
- Consumes `pc`, issues one-word reads to instruction memory and buffers returned instructions with their PC in a small queue for decode.
- Drives the PC register's `stall` so the PC advances only when a fetch is actually issued.
- Handles mispredict redirects by flushing the queue and squashing any in-flight response.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/fetch_queue.sv | 43 ++++
 rtl/pipeline_fetch.sv | 116 +++++++++++
 tb/tb_pipeline_fetch.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the fetch stage: FSM state encoding, queue entry layout
// and the full-word read mask.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN,
    WAIT,
    SQUASH
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [3:0] INST_RMASK = 4'hF;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries (PC + instruction) feeding decode.
// Flush clears occupancy and pointers in one cycle; the head is read combinationally.
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/pipeline_fetch.sv
// Instruction-fetch stage: one outstanding imem read, queue of fetched words, redirect squash.
// Optional macro FETCH_PERF_EN adds stall-cycle and squashed-response counters.
//
// state  | meaning
// RUN    | nothing outstanding
// WAIT   | request outstanding, response wanted
// SQUASH | request outstanding, response to be discarded
module pipeline_fetch
  import pipeline_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        mispredict_br_en,
  output logic        fetch_stall,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_squashed
`endif
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   out_pc;
  logic [CW-1:0] count;
  logic [CW:0]   count_next;
  logic          push;
  logic          pop;
  logic          issue;
  fetch_entry_t  head;
  fetch_entry_t  wentry;

  assign push       = imem_resp & (state == WAIT) & ~mispredict_br_en;
  assign id_valid   = ~rst & (count != '0) & ~mispredict_br_en;
  assign pop        = id_valid & id_ready;
  assign count_next = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};

  // The issued request's slot is reserved by comparing the post-update occupancy.
  assign issue = ~rst & ~mispredict_br_en
               & ((state == RUN) | ((state == WAIT) & imem_resp))
               & (count_next < (CW+1)'(QUEUE_DEPTH));

  assign fetch_stall = rst | (~issue & ~mispredict_br_en);
  assign imem_addr   = pc;
  assign imem_rmask  = issue ? INST_RMASK : 4'h0;
  assign wentry      = '{pc: out_pc, inst: imem_rdata};
  assign id_pc       = head.pc;
  assign id_inst     = head.inst;

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (issue) state_next = WAIT;
      WAIT: begin
        if (mispredict_br_en)  state_next = imem_resp ? RUN : SQUASH;
        else if (imem_resp)    state_next = issue ? WAIT : RUN;
      end
      SQUASH:  if (imem_resp) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      out_pc <= '0;
    end else begin
      state <= state_next;
      if (issue) out_pc <= pc;
    end
  end

  always @(posedge clk) begin
    if (!rst) assert (!((state == RUN) && imem_resp));
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (mispredict_br_en),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .count (count)
  );

`ifdef FETCH_PERF_EN
  logic drop;
  assign drop = imem_resp & ((state == SQUASH) | ((state == WAIT) & mispredict_br_en));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_squashed     <= '0;
    end else begin
      if (fetch_stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (drop)        perf_squashed     <= perf_squashed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_fetch.sv
// Directed bench for pipeline_fetch: PC-register and imem models plus an expected-entry queue.
module tb_pipeline_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h6000_0000;
  logic        mispredict_br_en = 1'b0;
  logic        fetch_stall;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_resp = 1'b0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_squashed;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mis_pc = 32'h0;
  int          lat = 1;
  bit          poison = 1'b0;
  bit          pend = 1'b0;
  bit          pend_doomed = 1'b0;
  bit          cur_doomed = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  bit          prev_rst = 1'b1;
  bit          prev_mis = 1'b0;
  bit          prev_stall = 1'b1;
  logic [63:0] sb[$];
  logic [63:0] exp_e;
  int          stall_done = 0;
  int          squash_done = 0;
  bit          stall_now = 1'b0;
  bit          squash_now = 1'b0;

  always #5 clk = ~clk;

  pipeline_fetch #(.QUEUE_DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc               (pc),
    .mispredict_br_en (mispredict_br_en),
    .fetch_stall      (fetch_stall),
    .imem_addr        (imem_addr),
    .imem_rmask       (imem_rmask),
    .imem_rdata       (imem_rdata),
    .imem_resp        (imem_resp),
    .id_valid         (id_valid),
    .id_ready         (id_ready),
    .id_pc            (id_pc),
    .id_inst          (id_inst)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_squashed    (perf_squashed)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, a[31:16] ^ 16'hABCD};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Environment: PC register, single-outstanding memory, and the expected-entry queue.
  always @(negedge clk) begin
    stall_done  += int'(stall_now);
    squash_done += int'(squash_now);
    if (prev_rst)        pc = 32'h6000_0000;
    else if (prev_mis)   pc = mis_pc;
    else if (!prev_stall) pc = pc + 32'd4;
    imem_resp  = 1'b0;
    cur_doomed = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_resp  = 1'b1;
        imem_rdata = poison ? 32'hDEADBEEF : mem_word(pend_addr);
        poison     = 1'b0;
        cur_doomed = pend_doomed;
        pend       = 1'b0;
        pend_doomed = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    #1;
    stall_now  = fetch_stall & ~rst;
    squash_now = imem_resp & (cur_doomed | mispredict_br_en) & ~rst;
    if (rst) begin
      pend = 1'b0;
      pend_doomed = 1'b0;
      sb.delete();
      stall_done = 0;
      squash_done = 0;
      stall_now = 1'b0;
      squash_now = 1'b0;
    end else begin
      if (imem_rmask == 4'hF) begin
        check("single_outstanding", {31'b0, pend}, 32'd0);
        check("imem_addr_is_pc", imem_addr, pc);
        sb.push_back({imem_addr, mem_word(imem_addr)});
        pend = 1'b1;
        pend_cnt = lat - 1;
        pend_addr = imem_addr;
        pend_doomed = 1'b0;
      end
      if (mispredict_br_en) begin
        sb.delete();
        if (pend) pend_doomed = 1'b1;
      end
      if (id_valid && id_ready) begin
        check("pop_has_expected", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          exp_e = sb.pop_front();
          check("id_pc", id_pc, exp_e[63:32]);
          check("id_inst", id_inst, exp_e[31:0]);
        end
      end
    end
    prev_rst   = rst;
    prev_mis   = mispredict_br_en;
    prev_stall = fetch_stall;
  end

  task automatic wait_issue(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #2;
      if (imem_rmask == 4'hF) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  bit          found;
  logic [31:0] held_addr;

  initial begin
    repeat (2) @(negedge clk);
    #2;
    check("rst_stall", {31'b0, fetch_stall}, 32'd1);
    check("rst_rmask", {28'b0, imem_rmask}, 32'h0);
    check("rst_valid", {31'b0, id_valid}, 32'd0);

    // Streaming with 1-cycle responses
    @(negedge clk); rst = 1'b0; id_ready = 1'b1; #2;
    check("first_rmask", {28'b0, imem_rmask}, 32'hF);
    check("first_addr", imem_addr, 32'h6000_0000);
    check("first_stall", {31'b0, fetch_stall}, 32'd0);
    check("valid_n0", {31'b0, id_valid}, 32'd0);
    @(negedge clk); #2;
    check("valid_n1", {31'b0, id_valid}, 32'd0);
    check("b2b_rmask", {28'b0, imem_rmask}, 32'hF);
    check("b2b_addr", imem_addr, 32'h6000_0004);
    @(negedge clk); #2;
    check("valid_n2", {31'b0, id_valid}, 32'd1);
    check("head_pc", id_pc, 32'h6000_0000);
    check("head_inst", id_inst, mem_word(32'h6000_0000));
    repeat (10) @(negedge clk);

    // Queue fills while decode is stalled
    @(negedge clk); rst = 1'b1; id_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    check("full_stall", {31'b0, fetch_stall}, 32'd1);
    check("full_rmask", {28'b0, imem_rmask}, 32'h0);
    check("full_valid", {31'b0, id_valid}, 32'd1);
    check("full_head_pc", id_pc, 32'h6000_0000);
    check("full_pc_held", imem_addr, 32'h6000_0008);
    @(negedge clk); #2;
    check("full_head_stable", id_pc, 32'h6000_0000);
    @(negedge clk); id_ready = 1'b1; #2;
    check("resume_rmask", {28'b0, imem_rmask}, 32'hF);
    check("resume_addr", imem_addr, 32'h6000_0008);
    repeat (6) @(negedge clk);

    // Mispredict with a request outstanding and no response
    lat = 3;
    repeat (8) @(negedge clk);
    wait_issue(found);
    check("wait_issue_squash", {31'b0, found}, 32'd1);
    @(negedge clk); mispredict_br_en = 1'b1; mis_pc = 32'h7000_0000; poison = 1'b1; #2;
    check("mis_stall", {31'b0, fetch_stall}, 32'd0);
    check("mis_rmask", {28'b0, imem_rmask}, 32'h0);
    check("mis_valid", {31'b0, id_valid}, 32'd0);
    @(negedge clk); mispredict_br_en = 1'b0; #2;
    check("squash_stall", {31'b0, fetch_stall}, 32'd1);
    check("squash_rmask", {28'b0, imem_rmask}, 32'h0);
    check("squash_valid", {31'b0, id_valid}, 32'd0);
    @(negedge clk); #2;
    check("drop_rmask", {28'b0, imem_rmask}, 32'h0);
    check("drop_valid", {31'b0, id_valid}, 32'd0);
    @(negedge clk); #2;
    check("redirect_rmask", {28'b0, imem_rmask}, 32'hF);
    check("redirect_addr", imem_addr, 32'h7000_0000);
    repeat (8) @(negedge clk);
    #2;
`ifdef FETCH_PERF_EN
    check("perf_squashed_1", perf_squashed, 32'd1);
    check("perf_stall_cycles", perf_stall_cycles, 32'(stall_done));
`endif

    // Mispredict coincident with the response
    @(negedge clk); lat = 2;
    repeat (8) @(negedge clk);
    wait_issue(found);
    check("wait_issue_coinc", {31'b0, found}, 32'd1);
    @(negedge clk);
    @(negedge clk); mispredict_br_en = 1'b1; mis_pc = 32'h7100_0000; #2;
    check("coinc_stall", {31'b0, fetch_stall}, 32'd0);
    check("coinc_rmask", {28'b0, imem_rmask}, 32'h0);
    @(negedge clk); mispredict_br_en = 1'b0; #2;
    check("coinc_redirect_rmask", {28'b0, imem_rmask}, 32'hF);
    check("coinc_redirect_addr", imem_addr, 32'h7100_0000);
    repeat (6) @(negedge clk);

    // Slow memory: PC held until the response returns
    lat = 5;
    repeat (12) @(negedge clk);
    wait_issue(found);
    check("wait_issue_slow", {31'b0, found}, 32'd1);
    held_addr = imem_addr + 32'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      check("slow_stall", {31'b0, fetch_stall}, 32'd1);
      check("slow_rmask", {28'b0, imem_rmask}, 32'h0);
      check("slow_pc_held", imem_addr, held_addr);
    end
    @(negedge clk); #2;
    check("slow_resume_rmask", {28'b0, imem_rmask}, 32'hF);
    check("slow_resume_addr", imem_addr, held_addr);

`ifdef FETCH_PERF_EN
    check("perf_squashed_2", perf_squashed, 32'd2);
    check("perf_stall_cycles_2", perf_stall_cycles, 32'(stall_done));
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #2;
    check("perf_rst_stall", perf_stall_cycles, 32'd0);
    check("perf_rst_squash", perf_squashed, 32'd0);
    @(negedge clk); rst = 1'b0;
`endif
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
